// File: rtl/qpp_interleaver_if.sv
// Handshake bundle for qpp_interleaver: parallel block in, bit-pair stream out.
// QPP_IDX_OUT_EN adds the int_idx observation signal.
interface qpp_interleaver_if #(
  parameter int K = 40
);
  logic [K-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sys_out;
  logic         int_out;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
`ifdef QPP_IDX_OUT_EN
  logic [$clog2(K)-1:0] int_idx;
`endif

  modport master (
    output din, din_valid, out_ready,
    input  din_ready, sys_out, int_out, out_last, out_valid
`ifdef QPP_IDX_OUT_EN
    , input int_idx
`endif
  );

  modport slave (
    input  din, din_valid, out_ready,
    output din_ready, sys_out, int_out, out_last, out_valid
`ifdef QPP_IDX_OUT_EN
    , output int_idx
`endif
  );
endinterface

// File: rtl/qpp_interleaver.sv
// QPP interleaver: streams c(i) and c(pi(i)) per handshake, pi built by add/compare-subtract.
// Optional QPP_IDX_OUT_EN exposes the current pi(i) on int_idx.
//
// state | meaning
// IDLE  | waiting for a code block on din (din_ready high once out of reset)
// RUN   | presenting position idx; advances on out_ready
module qpp_interleaver #(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10,
  parameter int IW = $clog2(K)
) (
  input logic              clk,
  input logic              rst,
  qpp_interleaver_if.slave bus
);

  localparam logic [IW:0]   KW   = (IW+1)'(K);
  localparam logic [IW-1:0] G0   = IW'((F1 + F2) % K);
  localparam logic [IW-1:0] D2   = IW'((2 * F2) % K);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [K-1:0]  blk;
  logic [IW-1:0] idx;
  logic [IW-1:0] pi;
  logic [IW-1:0] g;

  logic [K-1:0]  din_c;
  logic [K-1:0]  blk_c;
  logic [IW-1:0] idx_nx;
  logic [IW-1:0] pi_nx;
  logic [IW-1:0] g_nx;

  // Both operands are already reduced, so one conditional subtract suffices.
  function automatic logic [IW-1:0] mod_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= KW) s = s - KW;
    return s[IW-1:0];
  endfunction

  // c-order views: bit i holds c(i), so positions index directly
  always_comb begin
    din_c = '0;
    blk_c = '0;
    for (int i = 0; i < K; i++) begin
      din_c[i] = bus.din[K-1-i];
      blk_c[i] = blk[K-1-i];
    end
  end

  assign idx_nx = idx + IW'(1);
  assign pi_nx  = mod_add(pi, g);
  assign g_nx   = mod_add(g, D2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      blk           <= '0;
      idx           <= '0;
      pi            <= '0;
      g             <= '0;
      bus.din_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.sys_out   <= 1'b0;
      bus.int_out   <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.din_ready <= 1'b1;
          if (bus.din_valid && bus.din_ready) begin
            blk           <= bus.din;
            idx           <= '0;
            pi            <= '0;
            g             <= G0;
            state         <= RUN;
            bus.din_ready <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.sys_out   <= din_c[0];
            bus.int_out   <= din_c[0];
            bus.out_last  <= (K == 1);
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (idx == LAST) begin
              state         <= IDLE;
              bus.din_ready <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.sys_out   <= 1'b0;
              bus.int_out   <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              idx          <= idx_nx;
              pi           <= pi_nx;
              g            <= g_nx;
              bus.sys_out  <= blk_c[idx_nx];
              bus.int_out  <= blk_c[pi_nx];
              bus.out_last <= (idx_nx == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QPP_IDX_OUT_EN
  assign bus.int_idx = pi;
`endif

endmodule
